// File: rtl/mmr_scrubbed_register_bank.sv
// K-modular-redundant register bank: voted reads, debug copy injection,
// and a background scrub FSM that repairs copies disagreeing with the vote.
module mmr_scrubbed_register_bank #(
  parameter int K_MMR          = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int N_REGS         = 8,
  parameter int SCRUB_INTERVAL = 64,
  parameter int CNT_WIDTH      = 16,
  localparam int ADDR_W        = $clog2(N_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_W-1:0]     wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic [ADDR_W-1:0]     rd_addr_i,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  input  logic                  inject_en_i,
  input  logic [ADDR_W-1:0]     inject_addr_i,
  input  logic [2:0]            inject_copy_i,
  input  logic [DATA_WIDTH-1:0] inject_mask_i,
  input  logic                  scrub_en_i,
  output logic                  scrub_busy_o,
  output logic                  mismatch_o,
  output logic [CNT_WIDTH-1:0]  corr_count_o,
  input  logic                  corr_count_clr_i
);

  localparam int IVL_W = $clog2(SCRUB_INTERVAL);
  localparam logic [IVL_W-1:0]  IVL_LAST  = IVL_W'(SCRUB_INTERVAL - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_REGS - 1);

  if (K_MMR != 3 && K_MMR != 5) begin : g_bad_k
    $error("mmr_scrubbed_register_bank: K_MMR must be 3 or 5");
  end

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    FIX
  } state_t;

  state_t                  state;
  logic [IVL_W-1:0]        ivl;
  logic [ADDR_W-1:0]       ptr;
  logic [DATA_WIDTH-1:0]   fix_data;
  logic [DATA_WIDTH-1:0]   mem [K_MMR][N_REGS];

  logic [K_MMR*DATA_WIDTH-1:0] rd_flat;
  logic [K_MMR*DATA_WIDTH-1:0] sc_flat;
  logic [DATA_WIDTH-1:0]       sc_vote;
  logic                        sc_bad;

  function automatic logic [DATA_WIDTH-1:0] vote(
    input logic [K_MMR*DATA_WIDTH-1:0] w
  );
    logic [DATA_WIDTH-1:0] v;
    int ones;
    v = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      ones = 0;
      for (int k = 0; k < K_MMR; k++) begin
        if (w[k*DATA_WIDTH+b]) ones++;
      end
      v[b] = (ones > K_MMR / 2);
    end
    return v;
  endfunction

  always_comb begin
    rd_flat = '0;
    sc_flat = '0;
    for (int k = 0; k < K_MMR; k++) begin
      rd_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][rd_addr_i];
      sc_flat[k*DATA_WIDTH +: DATA_WIDTH] = mem[k][ptr];
    end
  end

  assign rd_data_o = vote(rd_flat);
  assign sc_vote   = vote(sc_flat);

  always_comb begin
    sc_bad = 1'b0;
    for (int k = 0; k < K_MMR; k++) begin
      if (mem[k][ptr] != sc_vote) sc_bad = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      ivl          <= '0;
      ptr          <= '0;
      fix_data     <= '0;
      scrub_busy_o <= 1'b0;
      mismatch_o   <= 1'b0;
      corr_count_o <= '0;
      for (int k = 0; k < K_MMR; k++) begin
        for (int a = 0; a < N_REGS; a++) begin
          mem[k][a] <= '0;
        end
      end
    end else begin
      mismatch_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!scrub_en_i) begin
            ivl <= '0;
          end else if (ivl == IVL_LAST) begin
            ivl          <= '0;
            ptr          <= '0;
            state        <= CHECK;
            scrub_busy_o <= 1'b1;
          end else begin
            ivl <= ivl + IVL_W'(1);
          end
        end
        CHECK: begin
          if (!scrub_en_i) begin
            ptr          <= '0;
            state        <= IDLE;
            scrub_busy_o <= 1'b0;
          end else if (sc_bad) begin
            fix_data   <= sc_vote;
            state      <= FIX;
            mismatch_o <= 1'b1;
          end else if (ptr == LAST_ADDR) begin
            state        <= IDLE;
            scrub_busy_o <= 1'b0;
          end else begin
            ptr <= ptr + ADDR_W'(1);
          end
        end
        FIX: begin
          if (ptr == LAST_ADDR) begin
            state        <= IDLE;
            scrub_busy_o <= 1'b0;
          end else begin
            ptr   <= ptr + ADDR_W'(1);
            state <= CHECK;
          end
        end
        default: begin
          state        <= IDLE;
          scrub_busy_o <= 1'b0;
        end
      endcase

      if (corr_count_clr_i) begin
        corr_count_o <= '0;
      end else if (state == FIX && corr_count_o != '1) begin
        corr_count_o <= corr_count_o + CNT_WIDTH'(1);
      end

      // Priority per copy: functional write, then scrub repair, then injection.
      for (int k = 0; k < K_MMR; k++) begin
        for (int a = 0; a < N_REGS; a++) begin
          if (wr_en_i && wr_addr_i == ADDR_W'(a)) begin
            mem[k][a] <= wr_data_i;
          end else if (state == FIX && ptr == ADDR_W'(a)) begin
            mem[k][a] <= fix_data;
          end else if (inject_en_i && inject_addr_i == ADDR_W'(a)
                       && inject_copy_i == 3'(k)) begin
            mem[k][a] <= mem[k][a] ^ inject_mask_i;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mmr_scrubbed_register_bank.sv
// Self-checking bench: read and sweep scoreboards against a word-level model
// of the redundant bank (K_MMR=3, N_REGS=8, SCRUB_INTERVAL=64).
module tb_mmr_scrubbed_register_bank;

  localparam int DW = 16;
  localparam int NR = 8;
  localparam int AW = 3;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          inj_en;
  logic [AW-1:0] inj_addr;
  logic [2:0]    inj_copy;
  logic [DW-1:0] inj_mask;
  logic          scrub_en;
  logic          busy;
  logic          mismatch;
  logic [15:0]   corr;
  logic          clr;

  mmr_scrubbed_register_bank dut (
    .clk              (clk),
    .rst              (rst),
    .wr_en_i          (wr_en),
    .wr_addr_i        (wr_addr),
    .wr_data_i        (wr_data),
    .rd_addr_i        (rd_addr),
    .rd_data_o        (rd_data),
    .inject_en_i      (inj_en),
    .inject_addr_i    (inj_addr),
    .inject_copy_i    (inj_copy),
    .inject_mask_i    (inj_mask),
    .scrub_en_i       (scrub_en),
    .scrub_busy_o     (busy),
    .mismatch_o       (mismatch),
    .corr_count_o     (corr),
    .corr_count_clr_i (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int busy;
    int fix;
  } sweep_t;

  int            checks;
  int            errors;
  logic [DW-1:0] exp_word [NR];
  logic [DW-1:0] rd_q [$];
  sweep_t        sw_q [$];
  int            gap_q [$];
  int            sweeps;
  int            busy_cnt;
  int            mm_cnt;
  int            gap;
  logic          prev_busy;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    sweep_t s;
    if (rst) begin
      busy_cnt  = 0;
      mm_cnt    = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        if (!prev_busy && gap_q.size() > 0) chk("gap", gap, gap_q.pop_front());
        busy_cnt++;
        if (mismatch) mm_cnt++;
      end else begin
        if (prev_busy) begin
          sweeps++;
          if (sw_q.size() > 0) begin
            s = sw_q.pop_front();
            chk("sweep_busy", busy_cnt, s.busy);
            chk("sweep_fix", mm_cnt, s.fix);
          end
          busy_cnt = 0;
          mm_cnt   = 0;
          gap      = 0;
        end
        gap++;
      end
      prev_busy = busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    exp_word[a] = d;
  endtask

  task automatic inj(input int a, input int c, input logic [DW-1:0] m);
    inj_en   = 1'b1;
    inj_addr = AW'(a);
    inj_copy = 3'(c);
    inj_mask = m;
    tick();
    inj_en = 1'b0;
  endtask

  task automatic rd_chk(input int a);
    rd_addr = AW'(a);
    rd_q.push_back(exp_word[a]);
    #1;
    chk($sformatf("rd%0d", a), rd_data, rd_q.pop_front());
  endtask

  task automatic rd_all();
    for (int a = 0; a < NR; a++) rd_chk(a);
  endtask

  task automatic push_sweep(input int b, input int f);
    sweep_t s;
    s.busy = b;
    s.fix  = f;
    sw_q.push_back(s);
  endtask

  task automatic wait_sweeps(input int n);
    int target;
    int cyc;
    target = sweeps + n;
    cyc = 0;
    while (sweeps < target && cyc < 400 * n) begin
      tick();
      cyc++;
    end
    if (sweeps < target) chk("sweep_timeout", 0, 1);
  endtask

  task automatic wait_fix();
    int cyc;
    cyc = 0;
    while (!mismatch && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!mismatch) chk("fix_timeout", 0, 1);
  endtask

  task automatic wait_busy();
    int cyc;
    cyc = 0;
    while (!busy && cyc < 400) begin
      tick();
      cyc++;
    end
    if (!busy) chk("busy_timeout", 0, 1);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    sweeps   = 0;
    busy_cnt = 0;
    mm_cnt   = 0;
    gap      = 0;
    prev_busy = 1'b0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr  = '0;
    inj_en   = 1'b0;
    inj_addr = '0;
    inj_copy = '0;
    inj_mask = '0;
    scrub_en = 1'b0;
    clr      = 1'b0;
    for (int a = 0; a < NR; a++) exp_word[a] = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("rst_busy", busy, 0);
    chk("rst_mismatch", mismatch, 0);
    chk("rst_corr", corr, 0);
    rd_all();

    wr(3, 16'hA5A5);
    rd_all();
    chk("corr0", corr, 0);

    // single-copy upset is masked, then repaired by the sweep
    wr(2, 16'h00FF);
    inj(2, 1, 16'hFFFF);
    rd_chk(2);
    push_sweep(9, 1);
    scrub_en = 1'b1;
    wait_sweeps(1);
    scrub_en = 1'b0;
    chk("corr_after_fix", corr, 1);
    // a second upset on another copy only votes correctly if copy 1 was restored
    inj(2, 0, 16'hFFFF);
    rd_chk(2);

    // write wins over same-address injection
    wr_en    = 1'b1;
    wr_addr  = 3'd5;
    wr_data  = 16'h5555;
    inj_en   = 1'b1;
    inj_addr = 3'd5;
    inj_copy = 3'd0;
    inj_mask = 16'hFFFF;
    tick();
    wr_en  = 1'b0;
    inj_en = 1'b0;
    exp_word[5] = 16'h5555;
    rd_chk(5);

    // continuous scrubbing: repair addr 2, then two clean sweeps 64 idle apart
    push_sweep(9, 1);
    scrub_en = 1'b1;
    wait_sweeps(1);
    gap_q.push_back(64);
    gap_q.push_back(64);
    push_sweep(8, 0);
    push_sweep(8, 0);
    wait_sweeps(2);
    scrub_en = 1'b0;
    chk("corr_two", corr, 2);
    rd_all();

    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("corr_clr", corr, 0);

    inj(0, 0, 16'h0001);
    inj(5, 1, 16'h8000);
    inj(7, 2, 16'hFFFF);
    rd_all();
    push_sweep(11, 3);
    scrub_en = 1'b1;
    wait_sweeps(1);
    scrub_en = 1'b0;
    chk("corr_three", corr, 3);
    rd_all();

    // clear during FIX beats the increment
    inj(4, 2, 16'h0F0F);
    push_sweep(9, 1);
    scrub_en = 1'b1;
    wait_fix();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_sweeps(1);
    scrub_en = 1'b0;
    chk("corr_clr_fix", corr, 0);
    rd_chk(4);

    // functional write during FIX at the same address wins
    inj(4, 1, 16'h00F0);
    push_sweep(9, 1);
    scrub_en = 1'b1;
    wait_fix();
    wr_en   = 1'b1;
    wr_addr = 3'd4;
    wr_data = 16'h1234;
    tick();
    wr_en = 1'b0;
    exp_word[4] = 16'h1234;
    wait_sweeps(1);
    chk("corr_wr_fix", corr, 1);
    rd_chk(4);
    push_sweep(8, 0);
    wait_sweeps(1);
    scrub_en = 1'b0;

    // disable mid-sweep at pointer 3
    push_sweep(4, 0);
    scrub_en = 1'b1;
    wait_busy();
    repeat (3) tick();
    scrub_en = 1'b0;
    wait_sweeps(1);
    chk("busy_off", busy, 0);
    inj(1, 2, 16'h0100);
    push_sweep(9, 1);
    scrub_en = 1'b1;
    wait_sweeps(1);
    scrub_en = 1'b0;
    chk("corr_restart", corr, 2);
    rd_all();

    // reset in the middle of a FIX
    inj(6, 0, 16'h0001);
    scrub_en = 1'b1;
    wait_fix();
    rst = 1'b1;
    tick();
    scrub_en = 1'b0;
    chk("rstfix_busy", busy, 0);
    chk("rstfix_mismatch", mismatch, 0);
    chk("rstfix_corr", corr, 0);
    rst = 1'b0;
    for (int a = 0; a < NR; a++) exp_word[a] = '0;
    tick();
    rd_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmr_scrubbed_register_bank.md
Name: mmr_scrubbed_register_bank

Overview:
- Register bank of N_REGS words, each stored as K_MMR redundant copies.
- Functional reads return the bitwise majority vote of the copies.
- A background scrub FSM periodically walks every address, detects copy disagreement and writes the voted value back to all copies.
- Sits beside the majority voter on the write/refresh side of the K-modular-redundant register path. A debug injection port corrupts single copies so SEU recovery can be exercised.

Parameters:
K_MMR, 3, number of redundant copies; legal values 3 or 5.
DATA_WIDTH, 16, bits per word.
N_REGS, 8, number of words; must be ≥2. ADDR_W = $clog2(N_REGS).
SCRUB_INTERVAL, 64, idle cycles between sweeps; must be ≥2.
CNT_WIDTH, 16, width of the correction counter.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
wr_en_i  input  1  functional write strobe.
wr_addr_i  input  ADDR_W  write address.
wr_data_i  input  DATA_WIDTH  write data; written to all copies.
rd_addr_i  input  ADDR_W  read address.
rd_data_o  output  DATA_WIDTH  combinational bitwise majority of copies at rd_addr_i.
inject_en_i  input  1  fault-injection strobe.
inject_addr_i  input  ADDR_W  injection address.
inject_copy_i  input  3  copy index to corrupt; values ≥K_MMR are ignored.
inject_mask_i  input  DATA_WIDTH  XOR mask applied to the selected copy.
scrub_en_i  input  1  enables background scrubbing.
scrub_busy_o  output  1  high while the FSM is in CHECK or FIX.
mismatch_o  output  1  one-cycle pulse when a word is corrected.
corr_count_o  output  CNT_WIDTH  saturating count of corrected words.
corr_count_clr_i  input  1  synchronous clear of corr_count_o.

Behaviour:
- Reset: all copies of all words = 0; FSM = IDLE; interval counter = 0; scrub pointer = 0; scrub_busy_o = 0; mismatch_o = 0; corr_count_o = 0. rst mid-sweep aborts immediately with the same values.
- Write: wr_en_i updates all K_MMR copies at wr_addr_i on the next edge. rd_data_o reflects new data the cycle after the write (no bypass).
- Vote: bit b of a word = 1 iff more than K_MMR/2 copies have bit b = 1.
- Injection: copy[inject_copy_i][inject_addr_i] ^= inject_mask_i on the next edge. Dropped if wr_en_i targets the same address in the same cycle (write wins).
- FSM IDLE:
  - Interval counter increments while scrub_en_i = 1; holds at 0 while scrub_en_i = 0.
  - When the counter = SCRUB_INTERVAL-1: counter <= 0, pointer <= 0, go CHECK.
- FSM CHECK (one cycle per address):
  - Compare all copies at the pointer.
  - If any copy differs from the vote: latch the voted value, go FIX.
  - Otherwise: if pointer = N_REGS-1, go IDLE; else pointer++.
  - If scrub_en_i = 0 on entry to CHECK: go IDLE, pointer <= 0, no check performed.
- FSM FIX (one cycle):
  - Write the latched vote to all copies at the pointer.
  - mismatch_o = 1 in this cycle (registered output, high during FIX).
  - corr_count_o++ (saturates at all-ones).
  - Then: if pointer = N_REGS-1, go IDLE; else pointer++ and go CHECK.
- Simultaneous events in FIX:
  - Functional write to the same address: functional write wins; the scrub writeback is dropped, but mismatch_o and the counter still fire.
  - Functional write to a different address: both writes happen.
  - Injection to the pointer address: injection dropped (the scrub write wins).
- Counter: corr_count_clr_i has priority over increment; the result is 0.
- Latency: an error-free sweep takes N_REGS CHECK cycles; each corrected word adds one FIX cycle. scrub_busy_o = 1 exactly during CHECK/FIX.
- Cases the design does not handle:
  - K_MMR = 3 with two copies corrupted identically: the wrong value wins the vote.
  - A simulation assertion fires if K_MMR ∉ {3,5}.

Test Plan:
- Reset, write 0xA5A5 to addr 3, read addr 3 -> rd_data_o = 0xA5A5; all other addresses read 0; corr_count_o = 0.
- Write 0x00FF to addr 2, inject mask 0xFFFF on copy 1, addr 2 -> rd_data_o still 0x00FF. Next sweep: exactly one mismatch_o pulse with scrub_busy_o high; corr_count_o = 1; copy 1 restored to 0x00FF.
- Scrub enabled, no errors, SCRUB_INTERVAL = 64, N_REGS = 8 -> scrub_busy_o high for 8 cycles every 72 cycles; mismatch_o never asserts.
- Inject into addrs 0, 5, 7 -> one sweep takes 11 busy cycles; corr_count_o = 3. Then assert corr_count_clr_i in the same cycle as a FIX -> count = 0.
- During FIX at addr 4, wr_en_i to addr 4 with 0x1234 -> all copies = 0x1234; mismatch_o pulses; count increments.
- Deassert scrub_en_i mid-sweep at pointer 3 -> after the current CHECK/FIX the FSM returns to IDLE; scrub_busy_o falls; the next sweep restarts at addr 0. Assert rst mid-FIX -> all outputs and storage = 0 on the next cycle.
